// File: rtl/bus_read_responder.sv
// Instruction-read memory responder: accepts byte addresses, looks up a word memory and
// returns the words in order after a fixed latency, with up to fifo_depth reads in flight.
module bus_read_responder #(
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int mem_depth_log2 = 10,
    parameter int fifo_depth     = 4,
    parameter int latency        = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               addr_valid,
    output logic                               addr_ready,
    input  logic [addr_width-1:0]              addr,
    output logic                               data_valid,
    input  logic                               data_ready,
    output logic [data_width-1:0]              data,
    input  logic                               load_en,
    input  logic [mem_depth_log2-1:0]          load_addr,
    input  logic [data_width-1:0]              load_data,
    output logic [$clog2(fifo_depth+1)-1:0]    outstanding,
    output logic                               err_misaligned
);

    localparam int mem_depth = 1 << mem_depth_log2;
    localparam int ptr_w     = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int cnt_w     = $clog2(fifo_depth + 1);
    localparam int cd_w      = $clog2(latency + 1);
    localparam logic [cd_w-1:0]  cd_init  = cd_w'(latency);
    localparam logic [ptr_w-1:0] ptr_last = ptr_w'(fifo_depth - 1);

    // Word memory; not under reset so it can be preloaded while the core is held.
    logic [data_width-1:0] mem_q [mem_depth];

    logic [data_width-1:0] word_q [fifo_depth];
    logic [data_width-1:0] word_d [fifo_depth];
    logic [cd_w-1:0]       cd_q   [fifo_depth];
    logic [cd_w-1:0]       cd_d   [fifo_depth];
    logic [fifo_depth-1:0] occ_q, occ_d;
    logic [ptr_w-1:0]      head_q, head_d, tail_q, tail_d;
    logic [cnt_w-1:0]      count_q, count_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;

    logic                      accept;
    logic                      pop;
    logic [mem_depth_log2-1:0] mem_idx;

    generate
        if (addr_width > mem_depth_log2 + 2) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[addr_width-1:mem_depth_log2+2];
        end
    endgenerate

    assign mem_idx        = addr[mem_depth_log2+1:2];
    assign accept         = addr_valid && ready_q;
    assign data_valid     = occ_q[head_q] && (cd_q[head_q] == '0);
    assign pop            = data_valid && data_ready;
    assign data           = data_valid ? word_q[head_q] : '0;
    assign addr_ready     = ready_q;
    assign outstanding    = count_q;
    assign err_misaligned = err_q;

    always_comb begin
        word_d  = word_q;
        cd_d    = cd_q;
        occ_d   = occ_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q;

        for (int i = 0; i < fifo_depth; i++) begin
            if (occ_q[i] && (cd_q[i] != '0)) begin
                cd_d[i] = cd_q[i] - cd_w'(1);
            end
        end

        if (pop) begin
            occ_d[head_q] = 1'b0;
            head_d        = (head_q == ptr_last) ? '0 : head_q + ptr_w'(1);
        end

        // Memory is read here, before this edge's backdoor write lands.
        if (accept) begin
            occ_d[tail_q]  = 1'b1;
            word_d[tail_q] = mem_q[mem_idx];
            cd_d[tail_q]   = cd_init;
            tail_d         = (tail_q == ptr_last) ? '0 : tail_q + ptr_w'(1);
            if (addr[1:0] != 2'b00) begin
                err_d = 1'b1;
            end
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + cnt_w'(1);
            2'b01:   count_d = count_q - cnt_w'(1);
            default: count_d = count_q;
        endcase

        ready_d = (count_d < cnt_w'(fifo_depth));
    end

    always_ff @(posedge clock) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        word_q <= word_d;
        cd_q   <= cd_d;
        if (!reset) begin
            occ_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_bus_read_responder.sv
// Randomised and directed checks of bus_read_responder against a queue-based reference model.
module tb_bus_read_responder;

    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic        clock;
    logic        reset;
    logic        addr_valid;
    logic        addr_ready;
    logic [31:0] addr;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] data;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
    logic [2:0]  outstanding;
    logic        err_misaligned;

    bus_read_responder #(
        .addr_width(32), .data_width(32), .mem_depth_log2(10),
        .fifo_depth(DEPTH), .latency(LAT)
    ) dut (
        .clock(clock), .reset(reset),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
        .data_valid(data_valid), .data_ready(data_ready), .data(data),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .outstanding(outstanding), .err_misaligned(err_misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] w;
        int          t;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mem_model [0:1023];
    int          edge_n;
    bit          m_ready;
    bit          m_valid;
    bit          m_err;
    int          total;
    int          bad;

    // Advance one clock and update the model from the inputs presented at that edge.
    task automatic step();
        bit       acc;
        bit       pp;
        logic [9:0] idx;
        ent_t     e;
        acc = addr_valid && m_ready;
        pp  = m_valid && data_ready;
        idx = addr[11:2];
        @(posedge clock);
        edge_n++;
        if (!reset) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            if (pp) q.delete(0);
            if (acc) begin
                e.w = mem_model[idx];
                e.t = edge_n;
                q.push_back(e);
                if (addr[1:0] != 2'b00) m_err = 1'b1;
            end
        end
        if (load_en) mem_model[load_addr] = load_data;
        #1;
        m_ready = reset && (q.size() < DEPTH);
        m_valid = reset && (q.size() > 0) && (edge_n >= q[0].t + LAT);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            load_en   = 1'b1;
            load_addr = 10'(i);
            load_data = (i == 0) ? 32'h00000013 : (i == 1) ? 32'h00100093 : $urandom;
            step();
        end
        load_en = 1'b0;
        total++; if (addr_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b expected 0", addr_ready); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", data_valid); end
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL rst_outst: got %0d expected 0", outstanding); end
        total++; if (err_misaligned !== 1'b0) begin bad++; $display("FAIL rst_err: got %b expected 0", err_misaligned); end
        total++; if (data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h expected 0", data); end
        reset = 1'b1;
        step();
        total++; if (addr_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b expected 1", addr_ready); end
    endtask

    task automatic test_single();
        data_ready = 1'b1;
        addr_valid = 1'b1;
        addr       = 32'h0;
        step();
        addr_valid = 1'b0;
        total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL single_outst_T: got %0d expected 1", outstanding); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL single_valid_T: got %b expected 0", data_valid); end
        step();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL single_valid_T1: got %b expected 0", data_valid); end
        step();
        total++; if (data_valid !== 1'b1 || data !== 32'h00000013) begin
            bad++; $display("FAIL single_data_T2: got valid=%b data=%h expected valid=1 data=00000013", data_valid, data);
        end
        total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL single_outst_T2: got %0d expected 1", outstanding); end
        step();
        total++; if (data_valid !== 1'b0 || outstanding !== 3'd0) begin
            bad++; $display("FAIL single_drain: got valid=%b outst=%0d expected 0/0", data_valid, outstanding);
        end
    endtask

    task automatic test_full();
        logic [31:0] exp_w [4];
        for (int i = 0; i < 4; i++) exp_w[i] = mem_model[i];
        data_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr_valid = 1'b1;
            addr       = 32'(i * 4);
            step();
        end
        total++; if (addr_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b expected 0", addr_ready); end
        total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL full_outst: got %0d expected 4", outstanding); end
        addr = 32'h10;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL full_no_fifth: got %0d expected 4", outstanding); end
        end
        addr_valid = 1'b0;
        data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (data_valid !== 1'b1 || data !== exp_w[i]) begin
                bad++; $display("FAIL full_order%0d: got valid=%b data=%h expected valid=1 data=%h", i, data_valid, data, exp_w[i]);
            end
            step();
            if (i == 0) begin
                total++; if (addr_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop: got %b expected 1", addr_ready); end
            end
        end
        total++; if (data_valid !== 1'b0 || outstanding !== 3'd0) begin
            bad++; $display("FAIL full_drain: got valid=%b outst=%0d expected 0/0", data_valid, outstanding);
        end
    endtask

    task automatic test_stall();
        int n;
        data_ready = 1'b0;
        addr_valid = 1'b1;
        addr       = 32'h4;
        step();
        addr_valid = 1'b0;
        n = 0;
        while (!data_valid && n < 20) begin step(); n++; end
        total++; if (data_valid !== 1'b1 || data !== 32'h00100093) begin
            bad++; $display("FAIL stall_first: got valid=%b data=%h expected valid=1 data=00100093", data_valid, data);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (data_valid !== 1'b1 || data !== 32'h00100093) begin
                bad++; $display("FAIL stall_hold%0d: got valid=%b data=%h expected valid=1 data=00100093", i, data_valid, data);
            end
        end
        data_ready = 1'b1;
        step();
        total++; if (data_valid !== 1'b0 || outstanding !== 3'd0) begin
            bad++; $display("FAIL stall_release: got valid=%b outst=%0d expected 0/0", data_valid, outstanding);
        end
    endtask

    task automatic test_misaligned();
        int n;
        data_ready = 1'b0;
        addr_valid = 1'b1;
        addr       = 32'h6;
        step();
        addr_valid = 1'b0;
        total++; if (err_misaligned !== 1'b1) begin bad++; $display("FAIL mis_err_set: got %b expected 1", err_misaligned); end
        n = 0;
        while (!data_valid && n < 20) begin step(); n++; end
        total++; if (data_valid !== 1'b1 || data !== 32'h00100093) begin
            bad++; $display("FAIL mis_data: got valid=%b data=%h expected valid=1 data=00100093", data_valid, data);
        end
        data_ready = 1'b1;
        step();
        step();
        total++; if (err_misaligned !== 1'b1) begin bad++; $display("FAIL mis_err_sticky: got %b expected 1", err_misaligned); end
    endtask

    task automatic test_load_collision();
        int n;
        data_ready = 1'b0;
        load_en    = 1'b1;
        load_addr  = 10'd2;
        load_data  = 32'h11111111;
        step();
        load_data  = 32'hDEADBEEF;
        addr_valid = 1'b1;
        addr       = 32'h8;
        step();
        load_en = 1'b0;
        step();
        addr_valid = 1'b0;
        n = 0;
        while (!data_valid && n < 20) begin step(); n++; end
        total++; if (data_valid !== 1'b1 || data !== 32'h11111111) begin
            bad++; $display("FAIL load_old_word: got valid=%b data=%h expected valid=1 data=11111111", data_valid, data);
        end
        data_ready = 1'b1;
        step();
        total++; if (data_valid !== 1'b1 || data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL load_new_word: got valid=%b data=%h expected valid=1 data=deadbeef", data_valid, data);
        end
        step();
        total++; if (data_valid !== 1'b0 || outstanding !== 3'd0) begin
            bad++; $display("FAIL load_drain: got valid=%b outst=%0d expected 0/0", data_valid, outstanding);
        end
    endtask

    task automatic test_random();
        int n;
        for (int c = 0; c < 400; c++) begin
            addr_valid = ($urandom_range(0, 2) != 0);
            addr       = {$urandom_range(0, 1) == 0 ? 20'h0 : 20'($urandom), 6'($urandom_range(0, 63)), 4'b0000, 2'($urandom_range(0, 3))};
            addr       = {addr[31:12], 2'b00, addr[9:0]};
            data_ready = ($urandom_range(0, 3) != 0);
            load_en    = ($urandom_range(0, 5) == 0);
            load_addr  = 10'($urandom_range(0, 63));
            load_data  = $urandom;
            step();
            total++; if (addr_ready !== m_ready || data_valid !== m_valid || outstanding !== 3'(q.size()) || err_misaligned !== m_err) begin
                bad++; $display("FAIL rand_ctrl c=%0d: got rdy=%b vld=%b outst=%0d err=%b expected rdy=%b vld=%b outst=%0d err=%b",
                                c, addr_ready, data_valid, outstanding, err_misaligned, m_ready, m_valid, q.size(), m_err);
            end
            if (m_valid) begin
                total++; if (data !== q[0].w) begin bad++; $display("FAIL rand_data c=%0d: got %h expected %h", c, data, q[0].w); end
            end
        end
        addr_valid = 1'b0;
        load_en    = 1'b0;
        data_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 40) begin step(); n++; end
        total++; if (outstanding !== 3'd0 || q.size() != 0) begin
            bad++; $display("FAIL rand_drain: got outst=%0d expected 0", outstanding);
        end
    endtask

    task automatic test_reset_mid();
        data_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            addr_valid = 1'b1;
            addr       = 32'(i * 4);
            step();
        end
        addr_valid = 1'b0;
        total++; if (outstanding !== 3'd2) begin bad++; $display("FAIL midrst_pre: got %0d expected 2", outstanding); end
        reset = 1'b0;
        step();
        total++; if (outstanding !== 3'd0 || data_valid !== 1'b0 || addr_ready !== 1'b0 || err_misaligned !== 1'b0) begin
            bad++; $display("FAIL midrst_during: got outst=%0d vld=%b rdy=%b err=%b expected 0/0/0/0",
                            outstanding, data_valid, addr_ready, err_misaligned);
        end
        reset      = 1'b1;
        data_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++; if (data_valid !== 1'b0 || outstanding !== 3'd0) begin
                bad++; $display("FAIL midrst_stale%0d: got vld=%b outst=%0d expected 0/0", i, data_valid, outstanding);
            end
        end
        total++; if (addr_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b expected 1", addr_ready); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        edge_n     = 0;
        m_ready    = 1'b0;
        m_valid    = 1'b0;
        m_err      = 1'b0;
        reset      = 1'b0;
        addr_valid = 1'b0;
        addr       = 32'h0;
        data_ready = 1'b0;
        load_en    = 1'b0;
        load_addr  = 10'd0;
        load_data  = 32'h0;

        test_reset();
        test_single();
        test_full();
        test_stall();
        test_misaligned();
        test_load_collision();
        test_random();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
